// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command framer and its I2C consumer.
package uart_cmd_pkg;

    localparam int unsigned CMD_W  = 66;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned OPND_W = 32;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // Opcodes understood by the I2C command state machine
    localparam logic [OP_W-1:0] OP_WRITE      = 2'b00;
    localparam logic [OP_W-1:0] OP_READ       = 2'b01;
    localparam logic [OP_W-1:0] OP_WRITE_READ = 2'b10;
    localparam logic [OP_W-1:0] OP_BUS_RESET  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_OPC  = 3'd1,
        ST_OPA  = 3'd2,
        ST_OPB  = 3'd3,
        ST_CHK  = 3'd4
    } state_t;

    function automatic logic [CMD_W-1:0] cmd_pack(input logic [OP_W-1:0]   op,
                                                  input logic [OPND_W-1:0] a,
                                                  input logic [OPND_W-1:0] b);
        return {op, a, b};
    endfunction

endpackage

// File: rtl/uart_cmd_assembler_timer.sv
// Inter-byte watchdog: counts idle cycles while enabled, pulses expired on the last one.
module inter_byte_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_r;

    // clear has priority, so a byte arriving on the terminal cycle suppresses expiry
    assign expired = enable && !clear && (count_r == LAST);

    // Idle-cycle counter; clear doubles as the synchronous restart
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear || expired) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/uart_cmd_assembler.sv
// Frames SYNC/OPC/A[3:0]/B[3:0]/CHK byte streams into 66-bit commands with valid/ack handoff.
module uart_cmd_assembler
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [CMD_W-1:0] cmd_word,
    output logic             cmd_valid,
    input  logic             cmd_ack,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);

    state_t            state_r, state_s;
    logic [1:0]        byte_cnt_r, byte_cnt_s;
    logic [7:0]        xor_r, xor_s;
    logic [OP_W-1:0]   op_r, op_s;
    logic [OPND_W-1:0] a_r, a_s, b_r, b_s;
    logic              load_s, err_s, ovr_s;
    logic              expired_s;

    inter_byte_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (reset_n),
        .clear  (rx_valid || (state_r == ST_IDLE)),
        .enable (state_r != ST_IDLE),
        .expired(expired_s)
    );

    // Next-state, datapath shifting and event decode
    always_comb begin
        state_s    = state_r;
        byte_cnt_s = byte_cnt_r;
        xor_s      = xor_r;
        op_s       = op_r;
        a_s        = a_r;
        b_s        = b_r;
        load_s     = 1'b0;
        err_s      = 1'b0;
        ovr_s      = 1'b0;
        if (expired_s) begin
            state_s = ST_IDLE;
            err_s   = 1'b1;
        end else if (rx_valid) begin
            case (state_r)
                ST_IDLE: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_s    = ST_OPC;
                        byte_cnt_s = 2'd0;
                        xor_s      = 8'h00;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_OPC: begin
                    if (rx_data[7:2] != 6'd0) begin
                        state_s = ST_IDLE;
                        err_s   = 1'b1;
                    end else begin
                        op_s       = rx_data[1:0];
                        xor_s      = rx_data;
                        byte_cnt_s = 2'd0;
                        state_s    = ST_OPA;
                    end
                end
                ST_OPA: begin
                    a_s        = {a_r[OPND_W-9:0], rx_data};
                    xor_s      = xor_r ^ rx_data;
                    byte_cnt_s = byte_cnt_r + 2'd1;
                    state_s    = (byte_cnt_r == 2'd3) ? ST_OPB : ST_OPA;
                end
                ST_OPB: begin
                    b_s        = {b_r[OPND_W-9:0], rx_data};
                    xor_s      = xor_r ^ rx_data;
                    byte_cnt_s = byte_cnt_r + 2'd1;
                    state_s    = (byte_cnt_r == 2'd3) ? ST_CHK : ST_OPB;
                end
                ST_CHK: begin
                    state_s = ST_IDLE;
                    if (rx_data != xor_r) begin
                        err_s = 1'b1;
                    end else if (!cmd_valid || cmd_ack) begin
                        load_s = 1'b1;
                    end else begin
                        ovr_s = 1'b1;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Frame assembly registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            byte_cnt_r <= 2'd0;
            xor_r      <= 8'h00;
            op_r       <= {OP_W{1'b0}};
            a_r        <= {OPND_W{1'b0}};
            b_r        <= {OPND_W{1'b0}};
        end else begin
            state_r    <= state_s;
            byte_cnt_r <= byte_cnt_s;
            xor_r      <= xor_s;
            op_r       <= op_s;
            a_r        <= a_s;
            b_r        <= b_s;
        end
    end

    // Output holding register and status pulses; a load in the ack cycle keeps valid high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_word  <= {CMD_W{1'b0}};
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            frame_err <= err_s;
            overrun   <= ovr_s;
            busy      <= (state_s != ST_IDLE);
            if (load_s) begin
                cmd_word  <= cmd_pack(op_r, a_r, b_r);
                cmd_valid <= 1'b1;
            end else if (cmd_ack) begin
                cmd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Directed, table-driven bench for uart_cmd_assembler with TIMEOUT_CYCLES=16.
module tb_uart_cmd_assembler;

    localparam int unsigned TMO = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [65:0] cmd_word;
    logic        cmd_valid;
    logic        cmd_ack;
    logic        frame_err;
    logic        overrun;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       name;
        int          n;
        logic [7:0]  b [13];
        logic        exp_valid;
        logic        exp_err;
        logic [65:0] exp_word;
    } vec_t;

    vec_t vecs [5];

    uart_cmd_assembler #(
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .cmd_word (cmd_word),
        .cmd_valid(cmd_valid),
        .cmd_ack  (cmd_ack),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Sends a vector; optionally raises cmd_ack alongside the final byte
    task automatic send_vec(input int i, input bit ack_last);
        for (int k = 0; k < vecs[i].n; k++) begin
            if (ack_last && (k == vecs[i].n - 1)) cmd_ack = 1'b1;
            send(vecs[i].b[k]);
        end
        cmd_ack = 1'b0;
    endtask

    task automatic do_ack(input string name);
        cmd_ack = 1'b1;
        @(negedge clk);
        cmd_ack = 1'b0;
        check({name, "_ack_clears"}, {65'd0, cmd_valid}, 66'd0);
    endtask

    task automatic run_vec(input int i);
        send_vec(i, 1'b0);
        check({vecs[i].name, "_valid"}, {65'd0, cmd_valid}, {65'd0, vecs[i].exp_valid});
        check({vecs[i].name, "_err"},   {65'd0, frame_err}, {65'd0, vecs[i].exp_err});
        check({vecs[i].name, "_ovr"},   {65'd0, overrun},   66'd0);
        check({vecs[i].name, "_busy"},  {65'd0, busy},      66'd0);
        if (vecs[i].exp_valid) begin
            check({vecs[i].name, "_word"}, cmd_word, vecs[i].exp_word);
            do_ack(vecs[i].name);
        end else begin
            @(negedge clk);
        end
        check({vecs[i].name, "_err_pulse"}, {65'd0, frame_err}, 66'd0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_word"},  cmd_word,             66'd0);
        check({name, "_valid"}, {65'd0, cmd_valid},   66'd0);
        check({name, "_err"},   {65'd0, frame_err},   66'd0);
        check({name, "_ovr"},   {65'd0, overrun},     66'd0);
        check({name, "_busy"},  {65'd0, busy},        66'd0);
    endtask

    initial begin
        vecs[0] = '{"good", 11,
                    '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h87, 8'h65, 8'h43, 8'h21, 8'h89, 8'h00, 8'h00},
                    1'b1, 1'b0, {2'b01, 32'h12345678, 32'h87654321}};
        vecs[1] = '{"badchk", 11,
                    '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h87, 8'h65, 8'h43, 8'h21, 8'h88, 8'h00, 8'h00},
                    1'b0, 1'b1, 66'd0};
        vecs[2] = '{"badopc", 2,
                    '{8'hA5, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    1'b0, 1'b1, 66'd0};
        vecs[3] = '{"syncdata", 11,
                    '{8'hA5, 8'h02, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00},
                    1'b1, 1'b0, {2'b10, 32'hA5A5A5A5, 32'h00000000}};
        vecs[4] = '{"garbage", 13,
                    '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h26},
                    1'b1, 1'b0, {2'b00, 32'hDEADBEEF, 32'h01020304}};

        reset_n  = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        cmd_ack  = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset");

        // Stray ack with nothing pending must not disturb anything
        cmd_ack = 1'b1;
        @(negedge clk);
        cmd_ack = 1'b0;
        check_all_zero("stray_ack");

        for (int i = 0; i < 5; i++) run_vec(i);

        // Truncated frame: expiry on the 16th idle cycle after the last byte
        for (int k = 0; k < 6; k++) send(vecs[0].b[k]);
        for (int k = 0; k < TMO - 1; k++) begin
            check("tmo_no_err_yet", {65'd0, frame_err}, 66'd0);
            @(negedge clk);
        end
        check("tmo_busy_before", {65'd0, busy}, 66'd1);
        @(negedge clk);
        check("tmo_err", {65'd0, frame_err}, 66'd1);
        check("tmo_idle", {65'd0, busy}, 66'd0);
        run_vec(0);

        // Overrun: second frame dropped while the first is still pending
        send_vec(0, 1'b0);
        check("ovr_first_valid", {65'd0, cmd_valid}, 66'd1);
        send_vec(3, 1'b0);
        check("ovr_pulse", {65'd0, overrun}, 66'd1);
        check("ovr_no_err", {65'd0, frame_err}, 66'd0);
        check("ovr_valid_held", {65'd0, cmd_valid}, 66'd1);
        check("ovr_word_kept", cmd_word, vecs[0].exp_word);
        @(negedge clk);
        check("ovr_pulse_single", {65'd0, overrun}, 66'd0);

        // Ack in the CHK cycle: new word loads with no gap in cmd_valid
        for (int k = 0; k < 11; k++) begin
            check("ackchk_valid_cont", {65'd0, cmd_valid}, 66'd1);
            if (k == 10) cmd_ack = 1'b1;
            send(vecs[3].b[k]);
        end
        cmd_ack = 1'b0;
        check("ackchk_valid", {65'd0, cmd_valid}, 66'd1);
        check("ackchk_no_ovr", {65'd0, overrun}, 66'd0);
        check("ackchk_word", cmd_word, vecs[3].exp_word);
        do_ack("ackchk");

        // Asynchronous reset mid-operand with a command pending
        send_vec(0, 1'b0);
        for (int k = 0; k < 4; k++) send(vecs[0].b[k]);
        check("midrst_busy_before", {65'd0, busy}, 66'd1);
        check("midrst_valid_before", {65'd0, cmd_valid}, 66'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_all_zero("midrst_release");
        run_vec(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
